// File: rtl/periodic_timer_if.sv
// Control and status bundle of the periodic timer: start/stop/config
// inputs from the controller and tick/status outputs back to it.
interface periodic_timer_if #(
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 8
);
  logic                      start_i;
  logic                      stop_i;
  logic                      mode_i;
  logic [WIDTH-1:0]          period_i;
  logic [PRESCALE_WIDTH-1:0] prescale_i;
  logic                      tick_o;
  logic                      busy_o;
  logic                      done_o;
  logic [WIDTH-1:0]          remaining_o;

  modport master (
    output start_i, stop_i, mode_i, period_i, prescale_i,
    input  tick_o, busy_o, done_o, remaining_o
  );

  modport slave (
    input  start_i, stop_i, mode_i, period_i, prescale_i,
    output tick_o, busy_o, done_o, remaining_o
  );
endinterface

// File: rtl/periodic_timer.sv
// Prescaled one-shot / periodic timer with a registered one-cycle tick pulse.
// IDLE -> RUN on an accepted start; RUN -> DONE (one-shot) or reload (periodic).
module periodic_timer #(
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  periodic_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_reg, state_next;
  logic                      mode_reg, mode_next;
  logic [WIDTH-1:0]          period_reg, period_next;
  logic [PRESCALE_WIDTH-1:0] prescale_reg, prescale_next;
  logic [PRESCALE_WIDTH-1:0] pcnt_reg, pcnt_next;
  logic [WIDTH-1:0]          remaining_reg, remaining_next;
  logic                      tick_reg, tick_next;

  logic start_ok;
  logic step_end;

  assign start_ok = bus.start_i && !bus.stop_i && (bus.period_i != '0);
  assign step_end = (pcnt_reg == prescale_reg);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg     <= IDLE;
      mode_reg      <= 1'b0;
      period_reg    <= '0;
      prescale_reg  <= '0;
      pcnt_reg      <= '0;
      remaining_reg <= '0;
      tick_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      period_reg    <= period_next;
      prescale_reg  <= prescale_next;
      pcnt_reg      <= pcnt_next;
      remaining_reg <= remaining_next;
      tick_reg      <= tick_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    period_next    = period_reg;
    prescale_next  = prescale_reg;
    pcnt_next      = pcnt_reg;
    remaining_next = remaining_reg;
    tick_next      = 1'b0;

    // Stop wins over start; a start or stop on the expiry edge drops that tick.
    if (bus.stop_i) begin
      state_next     = IDLE;
      pcnt_next      = '0;
      remaining_next = '0;
    end else if (start_ok) begin
      state_next     = RUN;
      mode_next      = bus.mode_i;
      period_next    = bus.period_i;
      prescale_next  = bus.prescale_i;
      pcnt_next      = '0;
      remaining_next = bus.period_i;
    end else begin
      case (state_reg)
        RUN: begin
          if (step_end) begin
            pcnt_next = '0;
            if (remaining_reg == WIDTH'(1)) begin
              tick_next = 1'b1;
              if (mode_reg) begin
                // Reload lands on the expiry edge itself so the period has no gap.
                remaining_next = period_reg;
              end else begin
                state_next     = DONE;
                remaining_next = '0;
              end
            end else begin
              remaining_next = remaining_reg - WIDTH'(1);
            end
          end else begin
            pcnt_next = pcnt_reg + PRESCALE_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.tick_o      = tick_reg;
  assign bus.busy_o      = (state_reg == RUN);
  assign bus.done_o      = (state_reg == DONE);
  assign bus.remaining_o = remaining_reg;

endmodule

// File: doc/periodic_timer.md
PERIODIC_TIMER -- requirements
Module: periodic_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: width of the period value and the remaining-count output.
REQ-002 The block SHALL have parameter PRESCALE_WIDTH, default 8: width of the prescale value.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start_i, input, 1 bit: start or restart request, sampled each clock edge.
REQ-006 The block SHALL have port stop_i, input, 1 bit: abort request, sampled each clock edge.
REQ-007 The block SHALL have port mode_i, input, 1 bit: 0 = one-shot, 1 = periodic; latched on an accepted start.
REQ-008 The block SHALL have port period_i, input, WIDTH bits, unsigned: number of prescaled steps per tick; latched on an accepted start.
REQ-009 The block SHALL have port prescale_i, input, PRESCALE_WIDTH bits, unsigned: each step lasts prescale_i+1 clock cycles; latched on an accepted start.
REQ-010 The block SHALL have port tick_o, output, 1 bit: one-cycle registered pulse at each period expiry; suitable as an enable input of a downstream counter.
REQ-011 The block SHALL have port busy_o, output, 1 bit: high while in state RUN.
REQ-012 The block SHALL have port done_o, output, 1 bit: high while in state DONE.
REQ-013 The block SHALL have port remaining_o, output, WIDTH bits: steps left in the current period; 0 outside RUN.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 An accepted start SHALL be start_i=1, stop_i=0 and period_i!=0, in any state.
REQ-016 On an accepted start, the block SHALL enter RUN, latch mode, period and prescale, and set the prescale counter to 0 and remaining to period_i.
REQ-017 A start with period_i=0 SHALL be ignored: state and all registers unchanged.
REQ-018 An accepted start in RUN SHALL restart the timer with the new values; a tick due on the same edge SHALL be suppressed.
REQ-019 In RUN with no start or stop, the prescale counter SHALL increment each cycle; when it equals the latched prescale it SHALL wrap to 0 and remaining SHALL decrement.
REQ-020 When remaining=1 and the prescale counter equals the latched prescale, the next edge SHALL set tick_o=1 for exactly one cycle.
REQ-021 At that edge, periodic mode SHALL reload remaining with the latched period and stay in RUN; one-shot mode SHALL go to DONE with remaining=0.
REQ-022 The first tick SHALL be asserted period*(prescale+1) cycles after the start-accepting edge; periodic ticks SHALL then repeat every period*(prescale+1) cycles, with no gap or extra cycle at reload.
REQ-023 stop_i=1 SHALL move any state to IDLE at the next edge, clear remaining and the prescale counter, and suppress any tick due on that edge.
REQ-024 stop_i SHALL have priority over start_i when both are asserted.
REQ-025 DONE SHALL persist until an accepted start (to RUN) or stop_i (to IDLE).
REQ-026 Period and prescale values SHALL reach their full ranges: period 2^WIDTH-1 and prescale 2^PRESCALE_WIDTH-1, with no overflow.
REQ-027 Changes to mode_i, period_i and prescale_i outside an accepted start SHALL have no effect.

Reset
REQ-028 When rstn_i=0, the block SHALL immediately, without waiting for a clock edge, force state IDLE, tick_o=0, busy_o=0, done_o=0, remaining_o=0, the prescale counter to 0 and all latched values to 0.
REQ-029 Reset asserted during RUN SHALL abort without producing a tick; operation SHALL resume only on an accepted start after rstn_i=1.

Verification
REQ-030 Scenario: one-shot, period=3, prescale=1, start pulsed once -> tick_o high exactly 6 cycles after the start edge; done_o=1 and busy_o=0 from that edge; remaining_o sequence 3,3,2,2,1,1,0.
REQ-031 Scenario: periodic, period=1, prescale=0 -> tick_o high every cycle from 1 cycle after start; stop_i then ends ticking at the next edge, with busy_o=0.
REQ-032 Scenario: periodic, period=4, prescale=2 for 40 cycles -> ticks at cycles 12, 24 and 36 after start; busy_o stays 1.
REQ-033 Scenario: start and stop asserted together in RUN -> IDLE, no tick; start with period_i=0 in IDLE -> no state change, busy_o=0.
REQ-034 Scenario: restart in RUN at cycle 5 with period=2, prescale=0 -> first tick 2 cycles after the restart edge; the original schedule is discarded.
REQ-035 Scenario: rstn_i pulled low mid-cycle during RUN -> all outputs 0 before the next clock edge; no tick after rstn_i rises until a new start.
